// File: rtl/ext_int_ctrl.sv
// External interrupt controller: synchronizes and de-glitches an asynchronous
// interrupt line, then tracks request/service handshaking with the CPU.
module ext_int_ctrl #(
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned FILT_CYCLES = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       ext_irq,
  input  logic       int_en,
  input  logic       int_ack,
  input  logic       eret,
  output logic       int_req,
  output logic       in_service,
  output logic       overrun,
  output logic [7:0] int_count
);

  typedef enum logic [2:0] {
    IDLE    = 3'b001,
    PENDING = 3'b010,
    SERVICE = 3'b100
  } state_t;

  localparam logic [3:0] RUN_LAST = 4'(FILT_CYCLES - 1);

  logic [SYNC_STAGES-1:0] sync_q;
  logic [SYNC_STAGES-1:0] sync_vld;
  logic                   sync_s;
  logic [3:0]             run_cnt;
  logic                   filt_lvl;
  logic                   filt_prev;
  logic                   armed;
  logic                   edge_evt;
  logic                   queued_q;
  state_t                 state_q;
  state_t                 state_d;

  // Synchronizer; sync_vld marks when the chain holds real samples rather than reset zeros.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync_q   <= '0;
      sync_vld <= '0;
    end else begin
      sync_q   <= {sync_q[SYNC_STAGES-2:0], ext_irq};
      sync_vld <= {sync_vld[SYNC_STAGES-2:0], 1'b1};
    end
  end

  assign sync_s = sync_q[SYNC_STAGES-1];

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      run_cnt   <= '0;
      filt_lvl  <= 1'b0;
      filt_prev <= 1'b0;
    end else begin
      filt_prev <= filt_lvl;
      if (sync_s != filt_lvl) begin
        if (run_cnt == RUN_LAST) begin
          filt_lvl <= sync_s;
          run_cnt  <= '0;
        end else begin
          run_cnt <= run_cnt + 4'd1;
        end
      end else begin
        run_cnt <= '0;
      end
    end
  end

  // Edges are only honoured once a genuine low has been seen after reset, so a
  // line held high through reset does not fire until it falls and rises again.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      armed <= 1'b0;
    end else if (sync_vld[SYNC_STAGES-1] && !sync_s) begin
      armed <= 1'b1;
    end
  end

  assign edge_evt = filt_lvl & ~filt_prev & armed;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: begin
        if (edge_evt) state_d = PENDING;
      end
      PENDING: begin
        if (int_ack && int_en) state_d = SERVICE;
      end
      SERVICE: begin
        // An edge arriving alongside eret counts as already queued.
        if (eret) state_d = (queued_q || edge_evt) ? PENDING : IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    int_req    = (state_q == PENDING) & int_en;
    in_service = (state_q == SERVICE);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      int_count <= '0;
      overrun   <= 1'b0;
      queued_q  <= 1'b0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (edge_evt) int_count <= int_count + 8'd1;
        end
        PENDING: begin
          if (edge_evt) overrun <= 1'b1;
        end
        SERVICE: begin
          if (edge_evt) begin
            if (queued_q) overrun <= 1'b1;
            else          int_count <= int_count + 8'd1;
          end
          if (eret)          queued_q <= 1'b0;
          else if (edge_evt) queued_q <= 1'b1;
        end
        default: begin
          queued_q <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ext_int_ctrl.sv
// Scenario bench for ext_int_ctrl; expected int_count values are queued when
// stimulus is driven and compared when the controller reacts.
module tb_ext_int_ctrl;

  logic       clk = 1'b0;
  logic       reset;
  logic       ext_irq;
  logic       int_en;
  logic       int_ack;
  logic       eret;
  logic       int_req;
  logic       in_service;
  logic       overrun;
  logic [7:0] int_count;

  int unsigned checks = 0;
  int unsigned errors = 0;
  int unsigned model_cnt = 0;
  logic [7:0]  exp_q[$];
  logic [7:0]  exp_v;

  ext_int_ctrl #(.SYNC_STAGES(2), .FILT_CYCLES(4)) dut (
    .clk(clk), .reset(reset), .ext_irq(ext_irq), .int_en(int_en),
    .int_ack(int_ack), .eret(eret), .int_req(int_req),
    .in_service(in_service), .overrun(overrun), .int_count(int_count)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int unsigned n);
    repeat (n) step();
  endtask

  task automatic do_reset();
    reset = 1'b0; ext_irq = 1'b0; int_ack = 1'b0; eret = 1'b0; int_en = 1'b1;
    exp_q.delete();
    model_cnt = 0;
    idle(3);
    reset = 1'b1;
    idle(5);
  endtask

  task automatic accept();
    model_cnt++;
    exp_q.push_back(8'(model_cnt));
  endtask

  task automatic pulse(input int unsigned len);
    ext_irq = 1'b1;
    idle(len);
    ext_irq = 1'b0;
    idle(12);
  endtask

  task automatic ack();
    int_ack = 1'b1; step(); int_ack = 1'b0;
  endtask

  task automatic do_eret();
    eret = 1'b1; step(); eret = 1'b0;
  endtask

  task automatic wait_req(input int unsigned budget, output int unsigned lat);
    int unsigned n = 0;
    while (!int_req && n < budget) begin
      step();
      n++;
    end
    lat = int_req ? n : 0;
  endtask

  task automatic test_reset();
    reset = 1'b0; ext_irq = 1'b0; int_ack = 1'b0; eret = 1'b0; int_en = 1'b1;
    #3;
    checks++; if (int_req !== 1'b0) begin errors++; $display("FAIL reset_int_req got %b want 0", int_req); end
    checks++; if (in_service !== 1'b0) begin errors++; $display("FAIL reset_in_service got %b want 0", in_service); end
    checks++; if (overrun !== 1'b0) begin errors++; $display("FAIL reset_overrun got %b want 0", overrun); end
    checks++; if (int_count !== 8'd0) begin errors++; $display("FAIL reset_count got %0d want 0", int_count); end
  endtask

  task automatic test_glitch();
    logic seen = 1'b0;
    do_reset();
    ext_irq = 1'b1;
    idle(2);
    ext_irq = 1'b0;
    for (int i = 0; i < 20; i++) begin
      step();
      if (int_req) seen = 1'b1;
    end
    checks++; if (seen !== 1'b0) begin errors++; $display("FAIL glitch_req got %b want 0", seen); end
    checks++; if (int_count !== 8'd0) begin errors++; $display("FAIL glitch_count got %0d want 0", int_count); end
    checks++; if (overrun !== 1'b0) begin errors++; $display("FAIL glitch_overrun got %b want 0", overrun); end
  endtask

  task automatic test_latency();
    int unsigned lat;
    do_reset();
    accept();
    ext_irq = 1'b1;
    wait_req(20, lat);
    step();
    ext_irq = 1'b0;
    checks++; if (lat !== 7) begin errors++; $display("FAIL latency got %0d want 7", lat); end
    exp_v = exp_q.pop_front();
    checks++; if (int_count !== exp_v) begin errors++; $display("FAIL latency_count got %0d want %0d", int_count, exp_v); end
    idle(12);
    ack();
    checks++; if (in_service !== 1'b1 || int_req !== 1'b0) begin
      errors++; $display("FAIL ack_service got svc=%b req=%b want svc=1 req=0", in_service, int_req); end
    do_eret();
    checks++; if (in_service !== 1'b0 || int_req !== 1'b0) begin
      errors++; $display("FAIL eret_idle got svc=%b req=%b want 0 0", in_service, int_req); end
  endtask

  task automatic test_second_in_service();
    do_reset();
    accept(); pulse(8);
    exp_v = exp_q.pop_front();
    checks++; if (int_req !== 1'b1 || int_count !== exp_v) begin
      errors++; $display("FAIL svc2_first got req=%b cnt=%0d want req=1 cnt=%0d", int_req, int_count, exp_v); end
    ack();
    accept(); pulse(8);
    checks++; if (in_service !== 1'b1 || int_req !== 1'b0 || overrun !== 1'b0) begin
      errors++; $display("FAIL svc2_hold got svc=%b req=%b ovr=%b want 1 0 0", in_service, int_req, overrun); end
    do_eret();
    exp_v = exp_q.pop_front();
    checks++; if (int_req !== 1'b1 || in_service !== 1'b0 || int_count !== exp_v) begin
      errors++; $display("FAIL svc2_eret got req=%b svc=%b cnt=%0d want 1 0 %0d", int_req, in_service, int_count, exp_v); end
  endtask

  task automatic test_overrun_service();
    do_reset();
    accept(); pulse(8);
    exp_v = exp_q.pop_front();
    checks++; if (int_count !== exp_v) begin errors++; $display("FAIL ovs_first got %0d want %0d", int_count, exp_v); end
    ack();
    accept(); pulse(8);
    exp_v = exp_q.pop_front();
    checks++; if (int_count !== exp_v || overrun !== 1'b0) begin
      errors++; $display("FAIL ovs_queued got cnt=%0d ovr=%b want %0d 0", int_count, overrun, exp_v); end
    exp_q.push_back(8'(model_cnt)); pulse(8);
    exp_v = exp_q.pop_front();
    checks++; if (int_count !== exp_v || overrun !== 1'b1) begin
      errors++; $display("FAIL ovs_second got cnt=%0d ovr=%b want %0d 1", int_count, overrun, exp_v); end
    exp_q.push_back(8'(model_cnt)); pulse(8);
    exp_v = exp_q.pop_front();
    checks++; if (int_count !== exp_v || overrun !== 1'b1) begin
      errors++; $display("FAIL ovs_third got cnt=%0d ovr=%b want %0d 1", int_count, overrun, exp_v); end
    do_eret();
    checks++; if (int_req !== 1'b1) begin errors++; $display("FAIL ovs_eret_pending got %b want 1", int_req); end
  endtask

  task automatic test_pending_overrun();
    do_reset();
    accept(); pulse(8);
    pulse(8);
    exp_v = exp_q.pop_front();
    checks++; if (overrun !== 1'b1 || int_req !== 1'b1 || int_count !== exp_v) begin
      errors++; $display("FAIL pend_ovr got ovr=%b req=%b cnt=%0d want 1 1 %0d", overrun, int_req, int_count, exp_v); end
  endtask

  task automatic test_int_en();
    do_reset();
    int_en = 1'b0;
    accept(); pulse(8);
    checks++; if (int_req !== 1'b0) begin errors++; $display("FAIL en_masked got %b want 0", int_req); end
    ack(); idle(2);
    checks++; if (in_service !== 1'b0) begin errors++; $display("FAIL en_ack_ignored got %b want 0", in_service); end
    int_en = 1'b1;
    #1;
    exp_v = exp_q.pop_front();
    checks++; if (int_req !== 1'b1 || int_count !== exp_v) begin
      errors++; $display("FAIL en_raise got req=%b cnt=%0d want 1 %0d", int_req, int_count, exp_v); end
    ack();
    checks++; if (in_service !== 1'b1) begin errors++; $display("FAIL en_ack got %b want 1", in_service); end
  endtask

  task automatic test_eret_edge_same_cycle();
    do_reset();
    accept(); pulse(8);
    exp_v = exp_q.pop_front();
    ack();
    accept();
    ext_irq = 1'b1;
    idle(6);
    eret = 1'b1; step(); eret = 1'b0;
    exp_v = exp_q.pop_front();
    checks++; if (int_req !== 1'b1 || in_service !== 1'b0 || int_count !== exp_v || overrun !== 1'b0) begin
      errors++; $display("FAIL same_cycle got req=%b svc=%b cnt=%0d ovr=%b want 1 0 %0d 0",
                         int_req, in_service, int_count, overrun, exp_v); end
    ext_irq = 1'b0;
    idle(12);
  endtask

  task automatic test_ignored();
    do_reset();
    do_eret(); ack(); idle(2);
    checks++; if (in_service !== 1'b0 || int_req !== 1'b0) begin
      errors++; $display("FAIL ign_idle got svc=%b req=%b want 0 0", in_service, int_req); end
    accept(); pulse(8);
    do_eret();
    exp_v = exp_q.pop_front();
    checks++; if (int_req !== 1'b1 || in_service !== 1'b0 || int_count !== exp_v) begin
      errors++; $display("FAIL ign_pending got req=%b svc=%b cnt=%0d want 1 0 %0d", int_req, in_service, int_count, exp_v); end
  endtask

  task automatic test_reset_mid_service();
    int unsigned lat;
    logic seen = 1'b0;
    do_reset();
    accept(); pulse(8);
    exp_v = exp_q.pop_front();
    ack();
    accept();
    ext_irq = 1'b1;
    idle(10);
    exp_v = exp_q.pop_front();
    checks++; if (int_count !== exp_v || in_service !== 1'b1) begin
      errors++; $display("FAIL rst_pre got cnt=%0d svc=%b want %0d 1", int_count, in_service, exp_v); end
    #2 reset = 1'b0;
    #1;
    checks++; if (int_req !== 1'b0 || in_service !== 1'b0 || overrun !== 1'b0 || int_count !== 8'd0) begin
      errors++; $display("FAIL rst_async got req=%b svc=%b ovr=%b cnt=%0d want all 0", int_req, in_service, overrun, int_count); end
    exp_q.delete();
    model_cnt = 0;
    idle(2);
    reset = 1'b1;
    for (int i = 0; i < 20; i++) begin
      step();
      if (int_req) seen = 1'b1;
    end
    checks++; if (seen !== 1'b0 || int_count !== 8'd0) begin
      errors++; $display("FAIL rst_held got req_seen=%b cnt=%0d want 0 0", seen, int_count); end
    ext_irq = 1'b0;
    idle(12);
    accept();
    ext_irq = 1'b1;
    wait_req(20, lat);
    ext_irq = 1'b0;
    checks++; if (lat !== 7) begin errors++; $display("FAIL rst_rearm_latency got %0d want 7", lat); end
    exp_v = exp_q.pop_front();
    checks++; if (int_count !== exp_v) begin errors++; $display("FAIL rst_rearm_count got %0d want %0d", int_count, exp_v); end
    idle(12);
  endtask

  task automatic test_wrap();
    do_reset();
    for (int unsigned i = 0; i < 255; i++) begin
      model_cnt++;
      pulse(8); ack(); do_eret();
    end
    exp_q.push_back(8'(model_cnt));
    exp_v = exp_q.pop_front();
    checks++; if (int_count !== exp_v) begin errors++; $display("FAIL wrap_255 got %0d want %0d", int_count, exp_v); end
    accept(); pulse(8);
    exp_v = exp_q.pop_front();
    checks++; if (int_count !== exp_v || overrun !== 1'b0 || int_req !== 1'b1) begin
      errors++; $display("FAIL wrap_0 got cnt=%0d ovr=%b req=%b want %0d 0 1", int_count, overrun, int_req, exp_v); end
  endtask

  initial begin
    test_reset();
    test_glitch();
    test_latency();
    test_second_in_service();
    test_overrun_service();
    test_pending_overrun();
    test_int_en();
    test_eret_edge_same_cycle();
    test_ignored();
    test_reset_mid_service();
    test_wrap();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
